// File: rtl/tape_ram.sv
// tape_ram: data-tape RAM with request/ready handshake, in-place INC/DEC and a registered zero flag.
// Optional post-reset clear sweep is enabled by defining RAM_CLEAR_EN.
module tape_ram #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic [1:0]            i_op,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_valid,
    output logic                  o_zero
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [DATA_WIDTH-1:0] D_ONE = DATA_WIDTH'(1);
`ifdef RAM_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_MODIFY, S_CLEAR} state_t;
    localparam state_t S_RESET = S_CLEAR;
`else
    typedef enum logic [1:0] {S_IDLE, S_MODIFY} state_t;
    localparam state_t S_RESET = S_IDLE;
`endif

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_dec;
    logic [DATA_WIDTH-1:0] r_temp;
    logic                  w_accept;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [DATA_WIDTH-1:0] w_result;
    logic [DATA_WIDTH-1:0] w_load;
`ifdef RAM_CLEAR_EN
    logic [ADDR_WIDTH-1:0] r_clr_addr;
`endif

    assign o_ready   = (r_state == S_IDLE);
    assign w_accept  = i_req && o_ready;
    assign w_rd_data = r_mem[i_address];
    assign w_result  = r_dec ? r_temp - D_ONE : r_temp + D_ONE;
    assign w_load    = i_op[0] ? i_data_in : w_rd_data;

    // state register; reset lands in the clear sweep when it is built in
    always_ff @(posedge i_clk) begin
        r_state <= i_rst ? S_RESET : w_next_state;
    end

    // next state: RMW takes one MODIFY cycle, sweep ends after the last address
    always_comb begin
        w_next_state = r_state;
        if (r_state == S_MODIFY)
            w_next_state = S_IDLE;
        else if (w_accept && i_op[1])
            w_next_state = S_MODIFY;
`ifdef RAM_CLEAR_EN
        else if (r_state == S_CLEAR && r_clr_addr == '1)
            w_next_state = S_IDLE;
`endif
    end

    // single write port shared by WRITE, RMW write-back and the clear sweep; reset blocks all writes
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = i_address;
        w_mem_wdata = i_data_in;
        if (r_state == S_MODIFY) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_addr;
            w_mem_wdata = w_result;
        end else if (w_accept && i_op == OP_WRITE) begin
            w_mem_we = 1'b1;
        end
`ifdef RAM_CLEAR_EN
        else if (r_state == S_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_addr;
            w_mem_wdata = '0;
        end
`endif
        if (i_rst)
            w_mem_we = 1'b0;
    end

    // storage array, contents survive reset
    always_ff @(posedge i_clk) begin
        if (w_mem_we)
            r_mem[w_mem_addr] <= w_mem_wdata;
    end

    // capture the RMW operand and target when INC/DEC is accepted
    always_ff @(posedge i_clk) begin
        if (w_accept && i_op[1]) begin
            r_addr <= i_address;
            r_dec  <= i_op[0];
            r_temp <= w_rd_data;
        end
    end

    // result register with zero flag and one-cycle valid pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data_out <= '0;
            o_valid    <= 1'b0;
            o_zero     <= 1'b1;
        end else begin
            o_valid <= 1'b0;
            if (r_state == S_MODIFY) begin
                o_data_out <= w_result;
                o_zero     <= (w_result == '0);
                o_valid    <= 1'b1;
            end else if (w_accept && !i_op[1]) begin
                o_data_out <= w_load;
                o_zero     <= (w_load == '0);
                o_valid    <= 1'b1;
            end
        end
    end

`ifdef RAM_CLEAR_EN
    // sweep address counts up while clearing and restarts from 0 on every reset
    always_ff @(posedge i_clk) begin
        if (i_rst || r_state != S_CLEAR)
            r_clr_addr <= '0;
        else
            r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
    end
`endif
endmodule

// File: tb/tb_tape_ram.sv
// tb_tape_ram: scoreboard bench for tape_ram (covers the clear sweep when RAM_CLEAR_EN is defined).
module tb_tape_ram;
`ifdef RAM_CLEAR_EN
    localparam int AW = 4;
    localparam logic RDY_RST = 1'b0;
`else
    localparam int AW = 16;
    localparam logic RDY_RST = 1'b1;
`endif
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din = '0;
    logic          ready;
    logic          valid;
    logic          zero;
    logic [DW-1:0] dout;
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    exp_t          sb[$];
    exp_t          e_mon;
    logic [DW-1:0] model[int];

    tape_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_req(req),
        .i_op(op),
        .i_address(addr),
        .i_data_in(din),
        .o_ready(ready),
        .o_data_out(dout),
        .o_valid(valid),
        .o_zero(zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // every valid pulse must match the oldest pending expectation in data, zero flag and cycle
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                check("data", 32'(dout), 32'(e_mon.d));
                check("zero", 32'(zero), 32'(e_mon.d == '0));
                check("latency", cyc, e_mon.c);
            end
        end
    end

    // call at a negedge; holds req until accepted and returns at the negedge after the accept edge
    task automatic issue(input logic [1:0] o, input int a, input logic [DW-1:0] d);
        int n = 0;
        logic [AW-1:0] aa = AW'(a);
        logic [DW-1:0] r;
        req = 1'b1;
        op = o;
        addr = aa;
        din = d;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("ready_timeout", 32'd0, 32'd1);
            req = 1'b0;
            return;
        end
        r = (o == 2'd0) ? model[int'(aa)] :
            (o == 2'd1) ? d :
            (o == 2'd2) ? model[int'(aa)] + 8'd1 : model[int'(aa)] - 8'd1;
        model[int'(aa)] = r;
        sb.push_back('{r, cyc + (o[1] ? 2 : 1)});
        @(posedge clk);
        @(negedge clk);
        if (o[1])
            check("rmw_ready_low", 32'(ready), 32'd0);
        req = 1'b0;
    endtask

    task automatic clear_model();
`ifdef RAM_CLEAR_EN
        for (int i = 0; i < (1 << AW); i++)
            model[i] = '0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'(RDY_RST));

        issue(2'd1, 'h10, 8'h5A);
        issue(2'd0, 'h10, 8'h00);

        issue(2'd1, 3, 8'hFF);
        issue(2'd2, 3, 8'h00);
        @(negedge clk);
        check("rdy_after_rmw", 32'(ready), 32'd1);
        issue(2'd0, 3, 8'h00);

        issue(2'd1, 4, 8'h00);
        issue(2'd3, 4, 8'h00);
        issue(2'd3, 4, 8'h00);

        for (int i = 1; i <= 4; i++) issue(2'd1, i, 8'(i * 17 + 1));
        for (int i = 1; i <= 4; i++) issue(2'd0, i, 8'h00);

        for (int i = 0; i < 24; i++)
            issue(2'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 8'($urandom));

        issue(2'd1, 'h20, 8'h33);
        req = 1'b1;
        op = 2'd2;
        addr = AW'('h20);
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_dout", 32'(dout), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_zero", 32'(zero), 32'd1);
        clear_model();
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'(RDY_RST));
        issue(2'd0, 'h20, 8'h00);

`ifdef RAM_CLEAR_EN
        for (int i = 0; i < 16; i++) issue(2'd1, i, 8'(i + 1));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req = 1'b1;
        op = 2'd0;
        addr = AW'(5);
        begin
            int cnt = 0;
            while (ready !== 1'b1 && cnt < 100) begin
                check("clear_dout", 32'(dout), 32'd0);
                @(negedge clk);
                cnt++;
            end
            req = 1'b0;
            check("clear_cycles", cnt, 16);
        end
        clear_model();
        for (int i = 0; i < 16; i++) issue(2'd0, i, 8'h00);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/tape_ram.md
Name: tape_ram

Overview:
- Parametrised synchronous data-tape RAM with a request/ready handshake and separate input and output data buses, replacing the single-port inout RAM.
- Adds in-place increment and decrement read-modify-write (RMW) operations for the cell +/- instructions.
- Adds a registered zero flag for loop tests, and an optional post-reset clear sweep.
- Sits between the sequencer and the data-tape storage; one requester.

Parameters:
- ADDR_WIDTH, 16, address bits; depth = 2^ADDR_WIDTH cells.
- DATA_WIDTH, 8, cell width in bits.

Ports:
- Clk  input  1  system clock; all activity on rising edge.
- Rst  input  1  synchronous reset, active-high.
- Req  input  1  command request; held with Op/Address/DataIn stable until accepted.
- Op  input  2  00 READ, 01 WRITE, 10 INC, 11 DEC.
- Address  input  ADDR_WIDTH  cell address.
- DataIn  input  DATA_WIDTH  write data; ignored except for WRITE.
- Ready  output  1  block can accept a command this cycle.
- DataOut  output  DATA_WIDTH  result of the last completed command; holds between commands.
- Valid  output  1  one-cycle pulse: DataOut updated this cycle.
- Zero  output  1  registered (DataOut == 0).

Behaviour:
- Interface: one clock (Clk); reset Rst is synchronous and active-high.
- Reset values: DataOut=0, Valid=0, Zero=1, internal state IDLE (CLEAR when RAM_CLEAR_EN is defined).
  - Ready=1 from the first cycle after Rst deasserts (0 during CLEAR when enabled).
- Accept: a command is accepted at an edge where Req=1 and Ready=1. Req while Ready=0 has no effect; the requester keeps holding it.
- States: CLEAR (optional), IDLE (Ready=1), MODIFY (Ready=0).
- READ:
  - At the accept edge, DataOut<=Mem[Address] and Valid<=1. Latency 1 cycle.
  - Stays in IDLE, so back-to-back reads run one per cycle.
- WRITE:
  - At the accept edge, Mem[Address]<=DataIn, DataOut<=DataIn (write-through) and Valid<=1.
  - Latency 1 cycle; back-to-back allowed.
- INC/DEC:
  - Accept edge: latch address and op, temp<=Mem[Address], go to MODIFY.
  - MODIFY edge: compute r = temp+1 or temp-1, modulo 2^DATA_WIDTH. Then Mem[addr]<=r, DataOut<=r, Valid<=1, back to IDLE.
  - Valid rises 2 cycles after accept; Ready is low for exactly 1 cycle.
- Wrap-around (DATA_WIDTH=8): INC 0xFF -> 0x00 with Zero=1; DEC 0x00 -> 0xFF with Zero=0.
- Read after write/RMW to the same address returns the new value; no hazard, since the RMW completes before Ready returns.
- Zero is updated on the same edge as DataOut (registered together, not a combinational decode).
- Valid is 0 on every cycle without a completion.
- Reset mid-operation:
  - Rst during MODIFY aborts the RMW; memory is unchanged and outputs take their reset values.
  - Rst during CLEAR restarts the sweep from address 0.
- Rst has priority over any accept in the same cycle.
- Memory contents are unaffected by Rst unless RAM_CLEAR_EN is defined.

Optional Feature:
- Macro RAM_CLEAR_EN.
- Defined:
  - After Rst deasserts, the FSM enters CLEAR and writes 0 to addresses 0 .. 2^ADDR_WIDTH-1, one per cycle, counting up.
  - Ready=0 for exactly 2^ADDR_WIDTH cycles, then IDLE with Ready=1.
  - Valid stays 0 and DataOut stays 0 throughout CLEAR.
- Not defined:
  - No CLEAR state and no sweep counter; Ready=1 the cycle after reset.
  - Memory contents are undefined until written (simulation X).

Test Plan:
- WRITE addr 0x0010 data 0x5A, then READ 0x0010 -> Valid pulse 1 cycle after each accept; READ gives DataOut=0x5A, Zero=0.
- WRITE 0x0003=0xFF, then INC 0x0003 -> Ready low 1 cycle; Valid 2 cycles after accept; DataOut=0x00, Zero=1; subsequent READ 0x0003=0x00.
- WRITE 0x0004=0x00, then DEC 0x0004 twice back-to-back with Req held -> second accepted when Ready returns; DataOut 0xFF then 0xFE.
- Four consecutive READs on addresses 1..4 with Req held high -> one accept per cycle; four consecutive Valid pulses with the matching data.
- INC accepted, then Rst asserted in the MODIFY cycle -> DataOut=0, Valid=0, Zero=1; READ of that address returns the original value.
- RAM_CLEAR_EN with ADDR_WIDTH=4: preload cells, pulse Rst -> Ready=0 for 16 cycles; Req during CLEAR is ignored; then READ of all 16 cells returns 0x00.
